// File: rtl/c_tile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : c_tile_pkg
//  Purpose  : Shared types, constants and the row packing helper for the
//             2x2 C tile packer.
//  Revision : 1.0  initial release
// ============================================================================
package c_tile_pkg;

  // Packer control states
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    EMIT    = 2'd2
  } state_t;

  // Elements per tile and row beats per tile
  localparam int TILE_BEATS = 4;
  localparam int ROW_BEATS  = 2;

  // Widest element the packing helper supports
  localparam int MAX_ELEM_W = 64;

  // Packs one row as {col1, col0}; col0 lands in the low elem_w bits.
  // Callers cast the result down to 2*elem_w bits.
  function automatic logic [2*MAX_ELEM_W-1:0] pack_row(
    input logic [MAX_ELEM_W-1:0] col0,
    input logic [MAX_ELEM_W-1:0] col1,
    input int unsigned           elem_w
  );
    logic [2*MAX_ELEM_W-1:0] lo;
    logic [2*MAX_ELEM_W-1:0] hi;
    lo = {{MAX_ELEM_W{1'b0}}, col0};
    hi = {{MAX_ELEM_W{1'b0}}, col1};
    return lo | (hi << elem_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/c_tile_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : c_tile_out_reg
//  Purpose  : Registered AXI-Stream source stage. A load captures a new beat
//             and raises tvalid; the beat is held unchanged under
//             backpressure and tvalid drops only after a handshake.
//  Revision : 1.0  initial release
// ============================================================================
module c_tile_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  output logic         tlast,
  input  logic         tready
);

  // Load has priority: the controller only loads when the slot is empty or
  // is being handed off this very cycle, so a held beat is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      tdata  <= load_data;
      tvalid <= 1'b1;
      tlast  <= load_last;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/c_tile_packer.sv
`default_nettype none
// ============================================================================
//  Module   : c_tile_packer
//  Purpose  : Collects a 4-beat row-major 2x2 C tile, checks its framing and
//             re-emits it as two row beats {col1, col0}. Malformed tiles are
//             dropped and flagged with a frame_err pulse.
//  Options  : define C_TILE_PACKER_ERRCNT_EN to add the saturating 8-bit
//             err_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module c_tile_packer
  import c_tile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_axis_c_tdata,
  input  logic                s_axis_c_tvalid,
  output logic                s_axis_c_tready,
  input  logic                s_axis_c_tlast,
  output logic [2*DATA_W-1:0] m_axis_r_tdata,
  output logic                m_axis_r_tvalid,
  input  logic                m_axis_r_tready,
  output logic                m_axis_r_tlast,
  output logic                tile_done,
  output logic                frame_err,
  output logic [CNT_W-1:0]    tile_cnt
`ifdef C_TILE_PACKER_ERRCNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  // DATA_W must not exceed MAX_ELEM_W (64) for the packing helper.

  state_t             state;
  state_t             state_next;
  logic [1:0]         beat;
  logic [1:0]         beat_next;
  logic               row;
  logic               row_next;
  logic [DATA_W-1:0]  tile_buf [TILE_BEATS];
  logic               buf_we;
  logic               in_hs;
  logic               out_hs;
  logic               load;
  logic [2*DATA_W-1:0] load_data;
  logic               load_last;
  logic               done_set;
  logic               err_set;
  logic [2*DATA_W-1:0] row0;
  logic [2*DATA_W-1:0] row1;

  // Ready is withheld while a tile is being emitted and during reset
  assign s_axis_c_tready = !rst && (state != EMIT);
  assign in_hs           = s_axis_c_tvalid && s_axis_c_tready;
  assign out_hs          = m_axis_r_tvalid && m_axis_r_tready;

  // Row images straight from the tile buffer
  assign row0 = (2*DATA_W)'(pack_row(MAX_ELEM_W'(tile_buf[0]),
                                     MAX_ELEM_W'(tile_buf[1]), DATA_W));
  assign row1 = (2*DATA_W)'(pack_row(MAX_ELEM_W'(tile_buf[2]),
                                     MAX_ELEM_W'(tile_buf[3]), DATA_W));

  // Next-state, buffer write and output-load decisions
  always_comb begin
    state_next = state;
    beat_next  = beat;
    row_next   = row;
    buf_we     = 1'b0;
    load       = 1'b0;
    load_data  = row0;
    load_last  = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      COLLECT: begin
        if (in_hs) begin
          buf_we = 1'b1;
          if (beat == 2'd3) begin
            beat_next = 2'd0;
            if (s_axis_c_tlast) begin
              // Elements 0 and 1 are already buffered, so row 0 can be
              // loaded on the same edge that captures element 3.
              state_next = EMIT;
              row_next   = 1'b0;
              load       = 1'b1;
              load_data  = row0;
              load_last  = 1'b0;
            end else begin
              // Overlong tile: flag once, then swallow up to its tlast
              err_set    = 1'b1;
              state_next = DRAIN;
            end
          end else if (s_axis_c_tlast) begin
            // Short tile: drop it and restart collection
            err_set   = 1'b1;
            beat_next = 2'd0;
          end else begin
            beat_next = beat + 2'd1;
          end
        end
      end
      DRAIN: begin
        if (in_hs && s_axis_c_tlast) begin
          state_next = COLLECT;
          beat_next  = 2'd0;
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (row == 1'b0) begin
            load      = 1'b1;
            load_data = row1;
            load_last = 1'b1;
            row_next  = 1'b1;
          end else begin
            row_next   = 1'b0;
            done_set   = 1'b1;
            state_next = COLLECT;
          end
        end
      end
      default: begin
        state_next = COLLECT;
        beat_next  = 2'd0;
        row_next   = 1'b0;
      end
    endcase
  end

  // Control state, status pulses and tile counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      beat      <= 2'd0;
      row       <= 1'b0;
      tile_done <= 1'b0;
      frame_err <= 1'b0;
      tile_cnt  <= '0;
    end else begin
      state     <= state_next;
      beat      <= beat_next;
      row       <= row_next;
      tile_done <= done_set;
      frame_err <= err_set;
      if (done_set) begin
        tile_cnt <= tile_cnt + CNT_W'(1);
      end
    end
  end

  // Tile element buffer; cleared on reset so no stale data survives
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TILE_BEATS; i++) begin
        tile_buf[i] <= '0;
      end
    end else if (buf_we) begin
      tile_buf[beat] <= s_axis_c_tdata;
    end
  end

`ifdef C_TILE_PACKER_ERRCNT_EN
  // Saturating count of dropped tiles, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_set && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  // Error counter not built in this configuration
`endif

  c_tile_out_reg #(
    .W (2*DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .tdata     (m_axis_r_tdata),
    .tvalid    (m_axis_r_tvalid),
    .tlast     (m_axis_r_tlast),
    .tready    (m_axis_r_tready)
  );

endmodule
`default_nettype wire

// File: tb/tb_c_tile_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c_tile_packer
//  Purpose  : Self-checking bench for c_tile_packer: directed framing cases
//             plus randomized tiles against a tile-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_c_tile_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        tile_done;
  logic        frame_err;
  logic [15:0] tile_cnt;
`ifdef C_TILE_PACKER_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  c_tile_packer #(.DATA_W(32), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_c_tdata  (s_tdata),
    .s_axis_c_tvalid (s_tvalid),
    .s_axis_c_tready (s_tready),
    .s_axis_c_tlast  (s_tlast),
    .m_axis_r_tdata  (m_tdata),
    .m_axis_r_tvalid (m_tvalid),
    .m_axis_r_tready (m_tready),
    .m_axis_r_tlast  (m_tlast),
    .tile_done       (tile_done),
    .frame_err       (frame_err),
    .tile_cnt        (tile_cnt)
`ifdef C_TILE_PACKER_ERRCNT_EN
    ,
    .err_cnt         (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (tile level) ----------------
  logic [64:0] exp_q[$];     // {last, row data}
  logic [31:0] part[$];      // elements of the tile being collected
  bit          draining = 0;
  int          exp_tiles = 0;
  int          exp_errs  = 0;
  int          obs_done  = 0;
  int          obs_err   = 0;

  task automatic model_accept(input logic [31:0] d, input logic l);
    if (draining) begin
      if (l) draining = 0;
    end else begin
      part.push_back(d);
      if (l) begin
        if (part.size() == 4) begin
          exp_q.push_back({1'b0, part[1], part[0]});
          exp_q.push_back({1'b1, part[3], part[2]});
          exp_tiles++;
        end else begin
          exp_errs++;
        end
        part.delete();
      end else if (part.size() == 4) begin
        exp_errs++;
        draining = 1;
        part.delete();
      end
    end
  endtask

  // ---------------- downstream ready generator ----------------
  int rmode   = 0;   // 0: always ready, 1: random, 2: 5-cycle stall per row
  int stall_n = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 3) != 0);
      default: begin
        if (m_tready) begin
          m_tready = 1'b0;
          stall_n  = 0;
        end else if (m_tvalid) begin
          stall_n++;
          if (stall_n >= 5) m_tready = 1'b1;
        end
      end
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  logic        rst_q = 1'b1;
  bit          stalled = 0;
  logic [63:0] hold_data;
  logic        hold_last;
  logic [64:0] e;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      if (rst_q) begin
        chk("rst_m_tvalid",  64'(m_tvalid),  64'd0);
        chk("rst_m_tdata",   m_tdata,        64'd0);
        chk("rst_m_tlast",   64'(m_tlast),   64'd0);
        chk("rst_tile_done", 64'(tile_done), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_tile_cnt",  64'(tile_cnt),  64'd0);
      end
      stalled = 0;
    end else begin
      if (tile_done || frame_err)
        chk("done_err_exclusive", 64'(tile_done & frame_err), 64'd0);
      if (tile_done) obs_done++;
      if (frame_err) obs_err++;
      if (m_tvalid) chk("s_tready_while_emit", 64'(s_tready), 64'd0);
      if (stalled) begin
        chk("hold_tvalid", 64'(m_tvalid), 64'd1);
        chk("hold_tdata",  m_tdata, hold_data);
        chk("hold_tlast",  64'(m_tlast), 64'(hold_last));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_row: got 0x%0h expected no output at %0t", m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("row_tdata", m_tdata, e[63:0]);
          chk("row_tlast", 64'(m_tlast), 64'(e[64]));
        end
      end
      stalled   = m_tvalid && !m_tready;
      hold_data = m_tdata;
      hold_last = m_tlast;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input logic [31:0] d, input logic l);
    bit hs;
    hs = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (hs) model_accept(d, l);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_beat_timeout: got tready 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic send_tile(input int len, input logic [31:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      send_beat(rnd ? $urandom() : base + 32'(i), (i == len - 1));
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = (exp_q.size() == 0) && !m_tvalid;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_reached", 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    exp_q.delete();
    part.delete();
    draining  = 0;
    exp_tiles = 0;
    exp_errs  = 0;
    obs_done  = 0;
    obs_err   = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_tile_done_count"}, 64'(obs_done), 64'(exp_tiles));
    chk({tag, "_frame_err_count"}, 64'(obs_err),  64'(exp_errs));
    chk({tag, "_tile_cnt"},        64'(tile_cnt), 64'(exp_tiles[15:0]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int len;
    do_reset();

    // Good tile with an always-ready sink; first row one cycle after tlast
    rmode = 0;
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd4, 1'b1);
    chk("latency_tvalid", 64'(m_tvalid), 64'd1);
    chk("latency_tdata",  m_tdata, 64'h00000002_00000001);
    chk("latency_tlast",  64'(m_tlast), 64'd0);
    wait_idle();
    chk("first_tile_cnt", 64'(tile_cnt), 64'd1);

    // Same tile with 5-cycle stalls per row
    rmode = 2;
    m_tready = 1'b0;
    send_tile(4, 32'd1, 0);
    wait_idle();
    rmode = 0;

    // Short tile (tlast on beat 2) then a good tile 5..8
    send_tile(2, 32'd100, 0);
    send_tile(4, 32'd5, 0);
    wait_idle();

    // Overlong tile of 6 beats, then a good tile
    send_tile(6, 32'd200, 0);
    send_tile(4, 32'd20, 0);
    wait_idle();
    check_counts("directed");

    // Reset after two accepted beats, then a good tile 9..12
    send_beat(32'd50, 1'b0);
    send_beat(32'd51, 1'b0);
    do_reset();
    send_tile(4, 32'd9, 0);
    wait_idle();
    check_counts("after_reset");

    // Randomized tiles with random backpressure
    rmode = 1;
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0, 1:    len = $urandom_range(1, 3);
        2:       len = $urandom_range(5, 7);
        default: len = 4;
      endcase
      send_tile(len, 32'd0, 1);
    end
    rmode = 0;
    wait_idle();
    check_counts("random");

`ifdef C_TILE_PACKER_ERRCNT_EN
    do_reset();
    for (int t = 0; t < 3; t++) send_tile(1, 32'd0, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("err_cnt_3", 64'(err_cnt), 64'd3);
    for (int t = 0; t < 297; t++) send_tile(1, 32'd0, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("err_cnt_sat", 64'(err_cnt), 64'd255);
`endif

    chk("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
